// File: rtl/pc_gen_btb.sv
// Fetch-stage PC generator with a direct-mapped BTB of 2-bit saturating counters.
// Next PC priority: trap, EX redirect, stall hold, BTB prediction, sequential.
module pc_gen_btb #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              BTB_ENTRIES  = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_target_i,
    input  logic            ex_redirect_i,
    input  logic [XLEN-1:0] ex_target_i,
    input  logic            ex_update_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic            ex_taken_i,
    input  logic [XLEN-1:0] ex_actual_target_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o
);
    localparam int IDX  = $clog2(BTB_ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;

    function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] a);
        return a & ~XLEN'(3);
    endfunction

    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] pc_next;

    logic [BTB_ENTRIES-1:0] valid_all;
    logic [1:0]             ctr_all    [BTB_ENTRIES];
    logic [TAGW-1:0]        tag_all    [BTB_ENTRIES];
    logic [XLEN-1:0]        target_all [BTB_ENTRIES];

    // Lookup side: indexed by the current fetch PC.
    logic [IDX-1:0]  rd_idx;
    logic [TAGW-1:0] rd_tag;
    logic            rd_hit;

    assign rd_idx = IDX'(pc_reg >> 2);
    assign rd_tag = TAGW'(pc_reg >> (IDX + 2));
    assign rd_hit = valid_all[rd_idx] && (tag_all[rd_idx] == rd_tag);

    assign pc_o          = pc_reg;
    assign pc_plus4_o    = pc_reg + XLEN'(4);
    assign pred_taken_o  = rd_hit && ctr_all[rd_idx][1];
    assign pred_target_o = pred_taken_o ? target_all[rd_idx] : '0;

    // Training side: indexed by the resolved instruction's PC.
    logic [IDX-1:0]  wr_idx;
    logic [TAGW-1:0] wr_tag;
    logic            wr_hit;
    logic [XLEN-1:0] wr_target;

    assign wr_idx    = IDX'(ex_pc_i >> 2);
    assign wr_tag    = TAGW'(ex_pc_i >> (IDX + 2));
    assign wr_hit    = valid_all[wr_idx] && (tag_all[wr_idx] == wr_tag);
    assign wr_target = align4(ex_actual_target_i);

    always_comb begin
        pc_next = pc_plus4_o;
        if (trap_valid_i) begin
            pc_next = align4(trap_target_i);
        end else if (ex_redirect_i) begin
            pc_next = align4(ex_target_i);
        end else if (stall_i) begin
            pc_next = pc_reg;
        end else if (pred_taken_o) begin
            pc_next = pred_target_o;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_reg <= RESET_VECTOR;
        end else begin
            pc_reg <= pc_next;
        end
    end

    for (genvar gi = 0; gi < BTB_ENTRIES; gi++) begin : g_entry
        logic            valid_reg;
        logic [1:0]      ctr_reg;
        logic [TAGW-1:0] tag_reg;
        logic [XLEN-1:0] target_reg;
        logic            sel;

        assign sel = ex_update_i && (wr_idx == IDX'(gi));

        // Writes land at the edge, so a same-cycle lookup still sees old contents.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                valid_reg  <= 1'b0;
                ctr_reg    <= 2'd0;
                tag_reg    <= '0;
                target_reg <= '0;
            end else if (sel) begin
                if (wr_hit) begin
                    if (ex_taken_i) begin
                        if (ctr_reg != 2'd3) begin
                            ctr_reg <= ctr_reg + 2'd1;
                        end
                        target_reg <= wr_target;
                    end else if (ctr_reg != 2'd0) begin
                        ctr_reg <= ctr_reg - 2'd1;
                    end
                end else if (ex_taken_i) begin
                    valid_reg  <= 1'b1;
                    tag_reg    <= wr_tag;
                    ctr_reg    <= 2'd2;
                    target_reg <= wr_target;
                end
            end
        end

        assign valid_all[gi]  = valid_reg;
        assign ctr_all[gi]    = ctr_reg;
        assign tag_all[gi]    = tag_reg;
        assign target_all[gi] = target_reg;
    end

endmodule

// File: tb/tb_pc_gen_btb.sv
// Directed bench for pc_gen_btb: reset, priority, stall, BTB training/aliasing, wrap, mid-run reset.
module tb_pc_gen_btb;
    logic        clock = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        trap_valid_i;
    logic [31:0] trap_target_i;
    logic        ex_redirect_i;
    logic [31:0] ex_target_i;
    logic        ex_update_i;
    logic [31:0] ex_pc_i;
    logic        ex_taken_i;
    logic [31:0] ex_actual_target_i;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    pc_gen_btb #(
        .XLEN         (32),
        .RESET_VECTOR (32'h100),
        .BTB_ENTRIES  (16)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .stall_i            (stall_i),
        .trap_valid_i       (trap_valid_i),
        .trap_target_i      (trap_target_i),
        .ex_redirect_i      (ex_redirect_i),
        .ex_target_i        (ex_target_i),
        .ex_update_i        (ex_update_i),
        .ex_pc_i            (ex_pc_i),
        .ex_taken_i         (ex_taken_i),
        .ex_actual_target_i (ex_actual_target_i),
        .pc_o               (pc_o),
        .pc_plus4_o         (pc_plus4_o),
        .pred_taken_o       (pred_taken_o),
        .pred_target_o      (pred_target_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic redirect(input logic [31:0] target);
        ex_redirect_i = 1'b1;
        ex_target_i   = target;
        tick();
        ex_redirect_i = 1'b0;
    endtask

    task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] target);
        ex_update_i        = 1'b1;
        ex_pc_i            = pc;
        ex_taken_i         = taken;
        ex_actual_target_i = target;
        tick();
        ex_update_i = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        stall_i = 1'b0;
        trap_valid_i = 1'b0;
        trap_target_i = '0;
        ex_redirect_i = 1'b0;
        ex_target_i = '0;
        ex_update_i = 1'b0;
        ex_pc_i = '0;
        ex_taken_i = 1'b0;
        ex_actual_target_i = '0;

        #2;
        check("reset_pc", pc_o, 32'h100);
        check("reset_pred", {31'd0, pred_taken_o}, 32'd0);
        check("reset_pred_tgt", pred_target_o, 32'd0);
        #1 reset = 1'b0;

        // Free-running sequential fetch from the reset vector.
        check("seq_pc0", pc_o, 32'h100);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("seq_pc%0d", i), pc_o, 32'h100 + 32'(4 * i));
            check($sformatf("seq_pred%0d", i), {31'd0, pred_taken_o}, 32'd0);
        end

        // Stall holds; EX redirect overrides stall and is word-aligned.
        redirect(32'h20);
        check("goto_20", pc_o, 32'h20);
        stall_i = 1'b1;
        tick();
        check("stall_hold1", pc_o, 32'h20);
        tick();
        check("stall_hold2", pc_o, 32'h20);
        redirect(32'h403);
        check("redir_over_stall", pc_o, 32'h400);
        stall_i = 1'b0;

        // Trap beats a simultaneous EX redirect.
        trap_valid_i  = 1'b1;
        trap_target_i = 32'h80;
        redirect(32'h200);
        trap_valid_i  = 1'b0;
        check("trap_priority", pc_o, 32'h80);

        // Training in the same cycle as the lookup: old contents seen.
        redirect(32'h40);
        check("at_40_cold", {31'd0, pred_taken_o}, 32'd0);
        train(32'h40, 1'b1, 32'h300);
        check("same_cycle_old", pc_o, 32'h44);
        redirect(32'h40);
        check("pred_hit", {31'd0, pred_taken_o}, 32'd1);
        check("pred_tgt", pred_target_o, 32'h300);
        tick();
        check("follow_pred", pc_o, 32'h300);

        // Counter 2 -> 1 -> 0: prediction drops out.
        train(32'h40, 1'b0, 32'h0);
        train(32'h40, 1'b0, 32'h0);
        redirect(32'h40);
        check("nt_pred", {31'd0, pred_taken_o}, 32'd0);
        check("nt_tgt", pred_target_o, 32'd0);
        tick();
        check("nt_seq", pc_o, 32'h44);

        // Counter 0 -> 1 -> 2 -> 3 -> 3, then one not-taken leaves 2.
        for (int i = 0; i < 4; i++) train(32'h40, 1'b1, 32'h503);
        train(32'h40, 1'b0, 32'h0);
        redirect(32'h40);
        check("sat_pred", {31'd0, pred_taken_o}, 32'd1);
        check("sat_tgt_align", pred_target_o, 32'h500);
        train(32'h40, 1'b0, 32'h0);
        redirect(32'h40);
        check("sat_down_pred", {31'd0, pred_taken_o}, 32'd0);

        // Aliasing: 0x80 shares index 0 with 0x40 and evicts it.
        train(32'h40, 1'b1, 32'h300);
        train(32'h80, 1'b1, 32'h600);
        redirect(32'h80);
        check("alias_80_pred", {31'd0, pred_taken_o}, 32'd1);
        check("alias_80_tgt", pred_target_o, 32'h600);
        redirect(32'h40);
        check("alias_40_miss", {31'd0, pred_taken_o}, 32'd0);

        // Sequential wrap at the top of the address space.
        redirect(32'hFFFF_FFFC);
        check("wrap_plus4", pc_plus4_o, 32'h0);
        tick();
        check("wrap_pc", pc_o, 32'h0);

        // Asynchronous reset mid-run clears PC and BTB at once.
        redirect(32'h80);
        check("pre_reset_pred", {31'd0, pred_taken_o}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midrst_pc", pc_o, 32'h100);
        check("midrst_pred", {31'd0, pred_taken_o}, 32'd0);
        #2 reset = 1'b0;
        tick();
        check("post_rst_pc", pc_o, 32'h104);
        redirect(32'h80);
        check("post_rst_btb", {31'd0, pred_taken_o}, 32'd0);
        tick();
        check("post_rst_seq", pc_o, 32'h84);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
